// File: rtl/fetch_stage_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_stage_pkg;

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    WAIT   = 2'd1,
    SQUASH = 2'd2
  } fetchState_e;

  // What the IF/ID register loads on the next edge.
  typedef enum logic [1:0] {
    IFID_HOLD   = 2'd0,
    IFID_BUBBLE = 2'd1,
    IFID_IMEM   = 2'd2,
    IFID_BUF    = 2'd3
  } ifidSel_e;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
  localparam logic [31:0] PC_STEP          = 32'd4;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/fetch_skid_buffer.sv
// One-entry holding buffer for an instruction that returns while IF/ID is stalled.
module fetch_skid_buffer
  import fetch_stage_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int INSTR_W = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic               drain,
  input  logic               clear,
  input  logic [INSTR_W-1:0] loadInstr,
  input  logic [ADDR_W-1:0]  loadPcPlus4,
  output logic               valid,
  output logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]  pcPlus4
);

  logic               valid_r;
  logic [INSTR_W-1:0] instr_r;
  logic [ADDR_W-1:0]  pcPlus4_r;

  // Entry storage: clear (redirect) beats load, load beats drain.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      valid_r   <= 1'b0;
      instr_r   <= INSTR_W'(NOP_INSTR);
      pcPlus4_r <= {ADDR_W{1'b0}};
    end else if (load) begin
      valid_r   <= 1'b1;
      instr_r   <= loadInstr;
      pcPlus4_r <= loadPcPlus4;
    end else if (drain) begin
      valid_r   <= 1'b0;
    end else begin
      valid_r   <= valid_r;
    end
  end

  assign valid   = valid_r;
  assign instr   = instr_r;
  assign pcPlus4 = pcPlus4_r;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC, imem request FSM and IF/ID register.
// Optional FETCH_BUF_EN adds a one-entry skid buffer for stalled returns.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter int                INSTR_W  = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEFAULT)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               write_pc,
  input  logic               write_ifid,
  input  logic               branch_taken,
  input  logic [ADDR_W-1:0]  branch_target,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ready,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [INSTR_W-1:0] ifid_instruction,
  output logic [ADDR_W-1:0]  ifid_pc_plus4,
  output logic               ifid_valid
);

  fetchState_e        state_r, nextState_s;
  ifidSel_e           ifidSel_s;
  logic [ADDR_W-1:0]  pc_r, nextPc_s, redirectPend_r, nextPend_s;
  logic [ADDR_W-1:0]  pcPlus4_s, target_s;
  logic               reqEn_r, reqActive_s, avail_s;
  logic [INSTR_W-1:0] ifidInstr_r;
  logic [ADDR_W-1:0]  ifidPcPlus4_r;
  logic               ifidValid_r;
  logic               bufValid_s;
  logic [INSTR_W-1:0] bufInstr_s;
  logic [ADDR_W-1:0]  bufPcPlus4_s;

  assign pcPlus4_s = pc_r + ADDR_W'(PC_STEP);
  assign target_s  = branch_target & {{(ADDR_W-2){1'b1}}, 2'b00};

  // A full skid buffer stands in for imem, so no request goes out meanwhile.
  assign reqActive_s = reqEn_r & ~bufValid_s;
  assign avail_s     = reqActive_s & imem_ready & (state_r != SQUASH);

`ifdef FETCH_BUF_EN
  localparam logic BUF_EN = 1'b1;

  fetch_skid_buffer #(
    .ADDR_W  (ADDR_W),
    .INSTR_W (INSTR_W)
  ) u_skid (
    .clk         (clk),
    .reset       (reset),
    .load        (avail_s & ~write_ifid & ~branch_taken),
    .drain       (write_ifid & bufValid_s),
    .clear       (branch_taken),
    .loadInstr   (imem_rdata),
    .loadPcPlus4 (pcPlus4_s),
    .valid       (bufValid_s),
    .instr       (bufInstr_s),
    .pcPlus4     (bufPcPlus4_s)
  );
`else
  localparam logic BUF_EN = 1'b0;

  assign bufValid_s   = 1'b0;
  assign bufInstr_s   = INSTR_W'(NOP_INSTR);
  assign bufPcPlus4_s = {ADDR_W{1'b0}};
`endif

  // Next-state, next-PC and IF/ID source selection.
  always_comb begin
    nextState_s = state_r;
    nextPc_s    = pc_r;
    nextPend_s  = redirectPend_r;
    ifidSel_s   = IFID_HOLD;
    if (branch_taken) begin
      ifidSel_s = IFID_BUBBLE;
      if ((state_r == FETCH && !(reqActive_s && !imem_ready)) ||
          (state_r != FETCH && imem_ready)) begin
        nextState_s = FETCH;
        nextPc_s    = target_s;
      end else begin
        // Response still owed for pc_r: keep the address, park the target.
        nextState_s = SQUASH;
        nextPend_s  = target_s;
      end
    end else begin
      case (state_r)
        FETCH, WAIT: begin
          if (avail_s) begin
            nextState_s = FETCH;
            if (write_ifid) begin
              if (write_pc) begin
                ifidSel_s = IFID_IMEM;
                nextPc_s  = pcPlus4_s;
              end else begin
                ifidSel_s = IFID_BUBBLE;
              end
            end else begin
              nextPc_s = BUF_EN ? pcPlus4_s : pc_r;
            end
          end else begin
            nextState_s = reqActive_s ? WAIT : FETCH;
            if (write_ifid) begin
              ifidSel_s = bufValid_s ? IFID_BUF : IFID_BUBBLE;
            end else begin
              ifidSel_s = IFID_HOLD;
            end
          end
        end
        SQUASH: begin
          if (imem_ready) begin
            nextState_s = FETCH;
            nextPc_s    = redirectPend_r;
          end else begin
            nextState_s = SQUASH;
          end
          ifidSel_s = write_ifid ? IFID_BUBBLE : IFID_HOLD;
        end
        default: begin
          nextState_s = FETCH;
          ifidSel_s   = IFID_BUBBLE;
        end
      endcase
    end
  end

  // PC, FSM state and request-enable registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r        <= FETCH;
      pc_r           <= RESET_PC;
      redirectPend_r <= {ADDR_W{1'b0}};
      reqEn_r        <= 1'b0;
    end else begin
      state_r        <= nextState_s;
      pc_r           <= nextPc_s;
      redirectPend_r <= nextPend_s;
      reqEn_r        <= 1'b1;
    end
  end

  // IF/ID pipeline register.
  always_ff @(posedge clk) begin
    if (reset) begin
      ifidInstr_r   <= INSTR_W'(NOP_INSTR);
      ifidPcPlus4_r <= {ADDR_W{1'b0}};
      ifidValid_r   <= 1'b0;
    end else begin
      case (ifidSel_s)
        IFID_BUBBLE: begin
          ifidInstr_r   <= INSTR_W'(NOP_INSTR);
          ifidPcPlus4_r <= {ADDR_W{1'b0}};
          ifidValid_r   <= 1'b0;
        end
        IFID_IMEM: begin
          ifidInstr_r   <= imem_rdata;
          ifidPcPlus4_r <= pcPlus4_s;
          ifidValid_r   <= 1'b1;
        end
        IFID_BUF: begin
          ifidInstr_r   <= bufInstr_s;
          ifidPcPlus4_r <= bufPcPlus4_s;
          ifidValid_r   <= 1'b1;
        end
        default: begin
          ifidInstr_r   <= ifidInstr_r;
          ifidPcPlus4_r <= ifidPcPlus4_r;
          ifidValid_r   <= ifidValid_r;
        end
      endcase
    end
  end

  assign imem_req         = reqActive_s;
  assign imem_addr        = pc_r;
  assign ifid_instruction = ifidInstr_r;
  assign ifid_pc_plus4    = ifidPcPlus4_r;
  assign ifid_valid       = ifidValid_r;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed self-checking bench for fetch_stage; imem returns an address-derived word.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        reset, write_pc, write_ifid, branch_taken, imem_ready;
  logic [31:0] branch_target;
  logic        imem_req;
  logic [31:0] imem_addr, imem_rdata;
  logic [31:0] ifid_instruction, ifid_pc_plus4;
  logic        ifid_valid;

  int nCompared   = 0;
  int nMismatched = 0;

  fetch_stage dut (
    .clk              (clk),
    .reset            (reset),
    .write_pc         (write_pc),
    .write_ifid       (write_ifid),
    .branch_taken     (branch_taken),
    .branch_target    (branch_target),
    .imem_req         (imem_req),
    .imem_addr        (imem_addr),
    .imem_ready       (imem_ready),
    .imem_rdata       (imem_rdata),
    .ifid_instruction (ifid_instruction),
    .ifid_pc_plus4    (ifid_pc_plus4),
    .ifid_valid       (ifid_valid)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] pat(input logic [31:0] a);
    return {a[15:0], ~a[15:0]};
  endfunction

  assign imem_rdata = pat(imem_addr);

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nCompared++;
    if (got !== exp) begin
      nMismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkIfid(input string tag, input logic [31:0] addr);
    checkVal({tag, "_valid"}, {31'd0, ifid_valid}, 32'd1);
    checkVal({tag, "_instr"}, ifid_instruction, pat(addr));
    checkVal({tag, "_pc4"}, ifid_pc_plus4, addr + 32'd4);
  endtask

  initial begin
    reset = 1'b1; write_pc = 1'b1; write_ifid = 1'b1;
    branch_taken = 1'b0; branch_target = 32'h0; imem_ready = 1'b1;

    // 1: reset state and streaming fetch
    tick(); tick();
    checkVal("rst_req", {31'd0, imem_req}, 32'd0);
    checkVal("rst_valid", {31'd0, ifid_valid}, 32'd0);
    checkVal("rst_instr", ifid_instruction, 32'h0);
    checkVal("rst_pc4", ifid_pc_plus4, 32'h0);
    checkVal("rst_addr", imem_addr, 32'h0);
    reset = 1'b0;
    tick();
    checkVal("first_req", {31'd0, imem_req}, 32'd1);
    checkVal("first_addr", imem_addr, 32'h0);
    tick();
    checkIfid("stream0", 32'h0);
    for (int i = 1; i <= 3; i++) begin
      tick();
      checkIfid("stream", 32'(4 * i));
    end
    checkVal("stream_addr", imem_addr, 32'h10);

    // 2: three wait cycles at 0x10
    imem_ready = 1'b0;
    for (int j = 0; j < 3; j++) begin
      tick();
      checkVal("wait_addr", imem_addr, 32'h10);
      checkVal("wait_req", {31'd0, imem_req}, 32'd1);
      checkVal("wait_bubble", {31'd0, ifid_valid}, 32'd0);
    end
    imem_ready = 1'b1;
    tick();
    checkIfid("wait_done", 32'h10);
    tick(); tick(); tick();
    checkIfid("pre_stall", 32'h1C);

    // 3: two-cycle stall at 0x20
    write_pc = 1'b0; write_ifid = 1'b0;
    for (int j = 0; j < 2; j++) begin
      tick();
      checkIfid("stall_hold", 32'h1C);
`ifdef FETCH_BUF_EN
      checkVal("stall_addr", imem_addr, 32'h24);
`else
      checkVal("stall_addr", imem_addr, 32'h20);
`endif
    end
    write_pc = 1'b1; write_ifid = 1'b1;
    tick();
    checkIfid("release0", 32'h20);
    tick();
    checkIfid("release1", 32'h24);

    // 4: redirect during WAIT, late response discarded
    imem_ready = 1'b0;
    tick();
    checkVal("sq_wait_addr", imem_addr, 32'h28);
    branch_taken = 1'b1; branch_target = 32'h103;
    tick();
    branch_taken = 1'b0;
    checkVal("sq_addr_held", imem_addr, 32'h28);
    checkVal("sq_req", {31'd0, imem_req}, 32'd1);
    checkVal("sq_bubble", {31'd0, ifid_valid}, 32'd0);
    tick();
    checkVal("sq_bubble2", {31'd0, ifid_valid}, 32'd0);
    imem_ready = 1'b1;
    tick();
    checkVal("sq_discard", {31'd0, ifid_valid}, 32'd0);
    checkVal("sq_target", imem_addr, 32'h100);
    tick();
    checkIfid("sq_fetch", 32'h100);

    // 5: redirect wins over IF/ID stall
    write_pc = 1'b0; write_ifid = 1'b0;
    branch_taken = 1'b1; branch_target = 32'h200;
    tick();
    checkVal("flush_valid", {31'd0, ifid_valid}, 32'd0);
    checkVal("flush_instr", ifid_instruction, 32'h0);
    checkVal("flush_addr", imem_addr, 32'h200);
    write_pc = 1'b1; write_ifid = 1'b1; branch_taken = 1'b0;
    tick();
    checkIfid("flush_fetch", 32'h200);

    // 6: PC wrap, then reset in the middle of WAIT
    branch_taken = 1'b1; branch_target = 32'hFFFF_FFFC;
    tick();
    branch_taken = 1'b0;
    checkVal("wrap_addr", imem_addr, 32'hFFFF_FFFC);
    tick();
    checkIfid("wrap", 32'hFFFF_FFFC);
    checkVal("wrap_next", imem_addr, 32'h0);
    tick();
    imem_ready = 1'b0;
    tick();
    checkVal("mid_wait_addr", imem_addr, 32'h4);
    reset = 1'b1;
    tick();
    checkVal("mid_rst_req", {31'd0, imem_req}, 32'd0);
    checkVal("mid_rst_addr", imem_addr, 32'h0);
    reset = 1'b0; imem_ready = 1'b1;
    tick();
    checkVal("late_ignored", {31'd0, ifid_valid}, 32'd0);
    checkVal("post_rst_req", {31'd0, imem_req}, 32'd1);
    tick();
    checkIfid("post_rst", 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
